// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshake on both sides.
//   Single-cycle ops (ADD..SRA, illegal) finish one cycle after acceptance.
//   MUL runs a radix-2 shift-add for WIDTH cycles.
//   With ALU_MC_DIV_EN defined, DIVU/REMU run a restoring divider for WIDTH
//   cycles; without it they are illegal ops (result 0).
//   The result is held in DONE until the consumer takes it.
// Ports:
//   clk, reset (async, active-high)
//   in_valid/in_ready, op, src1, src2   request side
//   out_valid/out_ready, result, zero   response side
//   busy                                high while in MUL or DIV
// Configuration macro: ALU_MC_DIV_EN (compiles in the divider)
module alu_mc #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OP_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam int unsigned SH_W  = $clog2(WIDTH);
  localparam int unsigned CNT_W = $clog2(WIDTH);

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SLTU = OP_W'(3);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SLL  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_SRL  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SRA  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(10);
`ifdef ALU_MC_DIV_EN
  localparam logic [OP_W-1:0] OP_DIVU = OP_W'(11);
  localparam logic [OP_W-1:0] OP_REMU = OP_W'(12);
`endif

`ifdef ALU_MC_DIV_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd3
  } state_t;
`endif

  state_t state_q, state_d;

  // opa/opb: multiplicand/multiplier during MUL, quotient/divisor during DIV.
  // acc: partial product during MUL, partial remainder during DIV.
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             in_ready_q, out_valid_q, busy_q;

  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] mul_sum;
  logic             last_iter;

`ifdef ALU_MC_DIV_EN
  logic             is_rem_q, is_rem_d;
  logic [WIDTH:0]   rem_shift;
  logic             div_ge;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
`endif

  assign shamt     = src2[SH_W-1:0];
  assign mul_sum   = acc_q + (opb_q[0] ? opa_q : '0);
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef ALU_MC_DIV_EN
  // Restoring step: shift next dividend bit into the remainder, subtract if it fits.
  // A zero divisor always "fits", which yields all-ones quotient and remainder = dividend.
  assign rem_shift = {acc_q, opa_q[WIDTH-1]};
  assign div_ge    = (rem_shift >= {1'b0, opb_q});
  assign rem_next  = div_ge ? WIDTH'(rem_shift - {1'b0, opb_q}) : WIDTH'(rem_shift);
  assign quo_next  = {opa_q[WIDTH-2:0], div_ge};
`endif

  // Single-cycle operations, computed straight from the request inputs.
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = src1 + src2;
      OP_SUB:  alu_res = src1 - src2;
      OP_SLT:  alu_res = WIDTH'($signed(src1) < $signed(src2));
      OP_SLTU: alu_res = WIDTH'(src1 < src2);
      OP_AND:  alu_res = src1 & src2;
      OP_OR:   alu_res = src1 | src2;
      OP_XOR:  alu_res = src1 ^ src2;
      OP_SLL:  alu_res = src1 << shamt;
      OP_SRL:  alu_res = src1 >> shamt;
      OP_SRA:  alu_res = WIDTH'($signed(src1) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
`ifdef ALU_MC_DIV_EN
    is_rem_d = is_rem_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opa_d = src1;
          opb_d = src2;
          acc_d = '0;
          cnt_d = '0;
          if (op == OP_MUL) begin
            state_d = MUL;
`ifdef ALU_MC_DIV_EN
          end else if (op == OP_DIVU || op == OP_REMU) begin
            state_d  = DIV;
            is_rem_d = (op == OP_REMU);
`endif
          end else begin
            state_d  = DONE;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
          end
        end
      end
      MUL: begin
        acc_d = mul_sum;
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          state_d  = DONE;
          result_d = mul_sum;
          zero_d   = (mul_sum == '0);
        end
      end
`ifdef ALU_MC_DIV_EN
      DIV: begin
        acc_d = rem_next;
        opa_d = quo_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          state_d  = DONE;
          result_d = is_rem_q ? rem_next : quo_next;
          zero_d   = ((is_rem_q ? rem_next : quo_next) == '0);
        end
      end
`endif
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; handshake flags track the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      opa_q       <= '0;
      opb_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ALU_MC_DIV_EN
      is_rem_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
`ifdef ALU_MC_DIV_EN
      busy_q      <= (state_d == MUL) || (state_d == DIV);
      is_rem_q    <= is_rem_d;
`else
      busy_q      <= (state_d == MUL);
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = result_q;
  assign zero      = zero_q;

endmodule
